// File: rtl/alu_unit_if.sv
// Operand/result bus between the operand mux side and the ALU stage.
interface alu_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] busIn;
  logic             loadA;
  logic             start;
  logic [2:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] regR;
  logic             zero;
  logic             negative;
  logic             carry;

  // Driver side: operand mux / sequencer
  modport master (
    output busIn, loadA, start, op,
    input  busy, done, regR, zero, negative, carry
  );

  // ALU side
  modport slave (
    input  busIn, loadA, start, op,
    output busy, done, regR, zero, negative, carry
  );
endinterface

// File: rtl/alu_unit.sv
// Sequential ALU stage: single-cycle logic/arithmetic ops plus an iterative
// shift-add multiply. Result lands in R, which feeds back to the operand mux.
module alu_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_unit_if.slave  bus
);

  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam int unsigned ProdW = 2 * WIDTH;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_r, w_r_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_neg, w_neg_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_done, w_done_nxt;
  logic [ProdW-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
  logic [ProdW-1:0] r_acc, w_acc_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [CntW-1:0]  w_shamt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic [ProdW-1:0] w_addend;
  logic [ProdW-1:0] w_acc_step;

  // Single-cycle result of A op busIn
  always_comb begin
    w_sum       = {1'b0, r_a} + {1'b0, bus.busIn};
    // A + ~B + 1: top bit set means no borrow, i.e. A >= B unsigned
    w_diff      = {1'b0, r_a} + {1'b0, ~bus.busIn} + {{WIDTH{1'b0}}, 1'b1};
    w_shamt     = bus.busIn[CntW-1:0];
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (bus.op)
      OpAdd: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      OpSub: begin
        w_alu_res   = w_diff[WIDTH-1:0];
        w_alu_carry = w_diff[WIDTH];
      end
      OpAnd:   w_alu_res = r_a & bus.busIn;
      OpOr:    w_alu_res = r_a | bus.busIn;
      OpXor:   w_alu_res = r_a ^ bus.busIn;
      OpShl:   w_alu_res = r_a << w_shamt;
      OpShr:   w_alu_res = r_a >> w_shamt;
      default: w_alu_res = '0; // MUL is handled by the iterative path
    endcase
  end

  // One shift-add multiply step for the current counter value
  always_comb begin
    w_addend   = r_mplier[r_cnt] ? (r_mcand << r_cnt) : '0;
    w_acc_step = r_acc + w_addend;
  end

  // Next-state and register update selection
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_r_nxt      = r_r;
    w_zero_nxt   = r_zero;
    w_neg_nxt    = r_neg;
    w_carry_nxt  = r_carry;
    w_done_nxt   = 1'b0;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          // start takes priority; a coincident loadA is dropped
          if (bus.op == OpMul) begin
            w_mcand_nxt  = {{WIDTH{1'b0}}, r_a};
            w_mplier_nxt = bus.busIn;
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
            w_state_nxt  = StMul;
          end else begin
            w_r_nxt     = w_alu_res;
            w_zero_nxt  = (w_alu_res == '0);
            w_neg_nxt   = w_alu_res[WIDTH-1];
            w_carry_nxt = w_alu_carry;
            w_done_nxt  = 1'b1;
          end
        end else if (bus.loadA) begin
          w_a_nxt = bus.busIn;
        end
      end
      StMul: begin
        w_acc_nxt = w_acc_step;
        w_cnt_nxt = r_cnt + 1'b1;
        // Last step writes R straight from the final sum, saving a cycle
        if (r_cnt == CntLast) begin
          w_r_nxt     = w_acc_step[WIDTH-1:0];
          w_zero_nxt  = (w_acc_step[WIDTH-1:0] == '0);
          w_neg_nxt   = w_acc_step[WIDTH-1];
          w_carry_nxt = |w_acc_step[ProdW-1:WIDTH];
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_r      <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_r      <= w_r_nxt;
      r_zero   <= w_zero_nxt;
      r_neg    <= w_neg_nxt;
      r_carry  <= w_carry_nxt;
      r_done   <= w_done_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.regR     = r_r;
  assign bus.zero     = r_zero;
  assign bus.negative = r_neg;
  assign bus.carry    = r_carry;
  assign bus.done     = r_done;
  assign bus.busy     = (r_state == StMul);

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit.
module tb_alu_unit;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpMul = 3'b111;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  alu_unit_if #(.WIDTH(16)) u_if ();

  alu_unit #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs reflect that edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [15:0] v);
    u_if.loadA = 1'b1;
    u_if.busIn = v;
    step();
    u_if.loadA = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [15:0] b);
    u_if.start = 1'b1;
    u_if.op    = op;
    u_if.busIn = b;
    step();
    u_if.start = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] r, input logic z,
                            input logic n, input logic c, input logic d, input logic b);
    check_val({tag, "_regR"}, 32'(u_if.regR), 32'(r));
    check_val({tag, "_zero"}, 32'(u_if.zero), 32'(z));
    check_val({tag, "_neg"}, 32'(u_if.negative), 32'(n));
    check_val({tag, "_carry"}, 32'(u_if.carry), 32'(c));
    check_val({tag, "_done"}, 32'(u_if.done), 32'(d));
    check_val({tag, "_busy"}, 32'(u_if.busy), 32'(b));
  endtask

  initial begin
    logic saw_done;
    int   waited;
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    u_if.busIn = '0;
    u_if.loadA = 1'b0;
    u_if.start = 1'b0;
    u_if.op    = '0;
    step();
    step();
    rst_n = 1'b1;

    // 1: random activity, then reset mid-MUL
    load_a(16'hABCD);
    start_op(OpAdd, 16'h1234);
    load_a(16'h0F0F);
    start_op(OpMul, 16'h00FF);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check_outs("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) step();
    check_outs("rst_hold", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: ADD overflow into sign bit, single done pulse
    load_a(16'h7FFF);
    start_op(OpAdd, 16'h0001);
    check_outs("add", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_val("add_done_once", 32'(u_if.done), 32'd0);
    check_val("add_hold", 32'(u_if.regR), 32'h8000);

    // 3: SUB and SHL
    load_a(16'h0005);
    start_op(OpSub, 16'h0005);
    check_outs("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    load_a(16'h0003);
    start_op(OpSub, 16'h0005);
    check_outs("sub_lt", 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    load_a(16'h0001);
    start_op(OpShl, 16'hFFF4);
    check_outs("shl", 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 4: MUL with mid-run noise that must be ignored
    load_a(16'h0123);
    start_op(OpMul, 16'h0010);
    check_val("mul_e0_busy", 32'(u_if.busy), 32'd1);
    check_val("mul_e0_done", 32'(u_if.done), 32'd0);
    for (int k = 1; k <= 15; k++) begin
      if (k == 5) begin
        u_if.start = 1'b1;
        u_if.op    = OpAdd;
        u_if.loadA = 1'b1;
        u_if.busIn = 16'hFFFF;
      end else begin
        u_if.start = 1'b0;
        u_if.loadA = 1'b0;
      end
      step();
      check_val($sformatf("mul_e%0d_busy", k), 32'(u_if.busy), 32'd1);
      check_val($sformatf("mul_e%0d_done", k), 32'(u_if.done), 32'd0);
      check_val($sformatf("mul_e%0d_regR", k), 32'(u_if.regR), 32'h0010);
    end
    step();
    check_outs("mul_e16", 16'h1230, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_val("mul_done_once", 32'(u_if.done), 32'd0);
    start_op(OpAdd, 16'h0000);
    check_val("mul_a_kept", 32'(u_if.regR), 32'h0123);

    load_a(16'h0100);
    start_op(OpMul, 16'h0100);
    waited = 0;
    while (u_if.done !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    check_val("mul2_latency", 32'(waited), 32'd16);
    check_outs("mul2", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // 5: reset at edge 8 of a MUL
    load_a(16'h0123);
    start_op(OpMul, 16'h0010);
    repeat (7) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_outs("mulrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      saw_done = saw_done | u_if.done;
    end
    check_val("mulrst_no_done", 32'(saw_done), 32'd0);
    check_val("mulrst_busy", 32'(u_if.busy), 32'd0);
    load_a(16'h0002);
    start_op(OpAdd, 16'h0003);
    check_outs("post_rst_add", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 6: start and loadA together; start wins, A unchanged
    load_a(16'h0011);
    u_if.loadA = 1'b1;
    start_op(OpOr, 16'h0100);
    u_if.loadA = 1'b0;
    check_outs("or_vs_load", 16'h0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    start_op(OpAdd, 16'h0000);
    check_val("a_kept", 32'(u_if.regR), 32'h0011);
    check_val("a_kept_done", 32'(u_if.done), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
Sequential 16-bit ALU stage that sits directly downstream of the operand mux and consumes its 16-bit `outData` bus.
- Operand A is latched from the bus in one cycle.
- Operand B is taken from the bus in the cycle the operation starts.
- The result is written to the R register, which feeds back to the operand mux as `regR`.
- Single-cycle logic/arithmetic ops are supported, plus an iterative 16-cycle shift-add multiply with a busy/done handshake.

Parameters:
WIDTH, 16, datapath width; all arithmetic rules below assume 16.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
busIn  input  WIDTH  operand bus, driven by the operand mux output
loadA  input  1  latch busIn into operand register A
start  input  1  begin operation `op`, with operand B = busIn in the same cycle
op  input  3  operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
busy  output  1  high while a MUL is in progress
done  output  1  one-cycle pulse when R and flags hold a new result
regR  output  WIDTH  result register R, fed back to the operand mux
zero  output  1  R == 0
negative  output  1  R[15]
carry  output  1  carry / no-borrow / overflow flag, see below

Behaviour:
- Reset: one clock, synchronous, active-low. On an edge with rst_n=0, the following are cleared, regardless of state including mid-MUL:
  - A, B, R, zero, negative, carry, done, busy → 0
  - internal counter and accumulator → 0
  - state → IDLE
- States:
  - IDLE: accepts loadA and start.
  - MUL: iterating; loadA and start are ignored with no side effects.
- loadA in IDLE with start=0: A <= busIn at that edge.
- start and loadA in the same IDLE cycle: start wins and uses the old A; loadA is dropped.
- start in IDLE with op != MUL:
  - At that edge, R <= f(A, busIn) and the flags update.
  - done=1 for exactly the following cycle; busy stays 0.
  - Latency is 1 edge.
- Op rules (result truncated to 16 bits):
  - ADD: R = A + B; carry = bit 16 of the 17-bit sum.
  - SUB: R = A - B, computed as A + ~B + 1; carry = 1 if A >= B unsigned (no borrow).
  - AND, OR, XOR: bitwise; carry = 0.
  - SHL: R = A << B[3:0]; SHR: R = A >> B[3:0], logical. B[15:4] is ignored. carry = 0.
  - MUL: R = low 16 bits of the unsigned 32-bit product A*B; carry = 1 if product[31:16] != 0.
  - zero = (new R == 0); negative = new R[15].
- MUL sequencing:
  - Start edge (edge 0): latch multiplicand A into a 32-bit register, latch multiplier B = busIn, clear the 32-bit accumulator, count=0. Set busy=1 and enter MUL.
  - Edges 1..16: if multiplier bit[count] is 1, the accumulator adds the multiplicand shifted left by count; then count increments.
  - Edge 16: R and flags are written from the final accumulator, busy=0, done=1 for one cycle, state returns to IDLE.
  - A new start is accepted on the cycle done is high (edge 17 at the earliest).
- R and flags hold their value until the next completed operation. A, and the A read by a MUL in progress, are unaffected by loadA during MUL.
- done is never high for more than one consecutive cycle unless two single-cycle ops complete back to back.

Test Plan:
1. Hold rst_n=0 for one edge after random activity → regR=0x0000, busy=0, done=0, zero=0, negative=0, carry=0; release, no stimulus → all outputs hold.
2. loadA with busIn=0x7FFF, then start op=ADD with busIn=0x0001 → next cycle regR=0x8000, negative=1, carry=0, zero=0, done=1 for one cycle only.
3. SUB cases:
   - A=0x0005, B=0x0005 → regR=0x0000, zero=1, carry=1.
   - A=0x0003, B=0x0005 → regR=0xFFFE, carry=0, negative=1.
   - SHL with A=0x0001, busIn=0xFFF4 → regR=0x0010.
4. MUL cases:
   - A=0x0123, B=0x0010: busy=1 for 16 cycles, done at edge 16, regR=0x1230, carry=0. An ADD start and a loadA issued mid-run are ignored (A still 0x0123 afterwards).
   - Then A=0x0100, B=0x0100 → regR=0x0000, zero=1, carry=1.
5. Assert rst_n=0 at edge 8 of a MUL → busy=0, regR=0, no done pulse. Then ADD with A=2, B=3 → regR=0x0005.
6. With A=0x0011 in IDLE, assert start(op=OR, busIn=0x0100) and loadA in the same cycle → regR=0x0111 and A remains 0x0011, verified by a following ADD with busIn=0 giving regR=0x0011.
